// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 decryption: forward key expansion, then inverse cipher with on-the-fly inverse key schedule.
// Latency: 21 cycles from accept to out_valid (full key path), 11 cycles when the cached last round key is reused.
// Backpressure: plaintext held on out_valid/pt_out until out_ready; start is accepted only in IDLE (ready), otherwise dropped.
module aes128_decrypt_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         reuse_key,
    input  logic [127:0] key_in,
    input  logic [127:0] ct_in,
    output logic         ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         key_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_KEXP = 2'd1;
    localparam logic [1:0] S_DEC  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // GF(2^8) multiply by x, reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i of the block lives at [127-8i -: 8]; byte index = 4*col + row
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] kcache_q, kcache_d;
    logic         key_valid_q, key_valid_d;

    logic [7:0]   rc;
    logic [127:0] k_fwd;
    logic [127:0] k_inv;
    logic [127:0] st_inv;
    logic [31:0]  fwd_t;
    logic [31:0]  inv_w3, inv_w2, inv_w1, inv_w0;

    // Round-key steps in both directions and the shared InvShiftRows/InvSubBytes stage
    always_comb begin
        rc     = rcon(rnd_q);
        fwd_t  = sub_rot_word(rk_q[31:0]) ^ {rc, 24'h0};
        k_fwd[127:96] = rk_q[127:96] ^ fwd_t;
        k_fwd[95:64]  = rk_q[95:64] ^ k_fwd[127:96];
        k_fwd[63:32]  = rk_q[63:32] ^ k_fwd[95:64];
        k_fwd[31:0]   = rk_q[31:0] ^ k_fwd[63:32];
        inv_w3 = rk_q[31:0] ^ rk_q[63:32];
        inv_w2 = rk_q[63:32] ^ rk_q[95:64];
        inv_w1 = rk_q[95:64] ^ rk_q[127:96];
        inv_w0 = rk_q[127:96] ^ sub_rot_word(inv_w3) ^ {rc, 24'h0};
        k_inv  = {inv_w0, inv_w1, inv_w2, inv_w3};
        st_inv = inv_shift_sub(st_q);
    end

    // Next-state control: accept, key expansion, inverse rounds, output hold
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        kcache_d    = kcache_q;
        key_valid_d = key_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_d = ct_in;
                    if (reuse_key && key_valid_q) begin
                        rk_d    = kcache_q;
                        rnd_d   = 4'd10;
                        state_d = S_DEC;
                    end else begin
                        rk_d    = key_in;
                        rnd_d   = 4'd1;
                        state_d = S_KEXP;
                    end
                end
            end
            S_KEXP: begin
                rk_d = k_fwd;
                if (rnd_q == 4'd10) begin
                    kcache_d    = k_fwd;
                    key_valid_d = 1'b1;
                    state_d     = S_DEC;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DEC: begin
                if (rnd_q == 4'd10) begin
                    st_d = st_q ^ rk_q;
                end else if (rnd_q == 4'd0) begin
                    st_d    = st_inv ^ rk_q;
                    state_d = S_OUT;
                end else begin
                    st_d = inv_mix(st_inv ^ rk_q);
                end
                if (rnd_q != 4'd0) begin
                    rk_d  = k_inv;
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset also drops the cached key
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            kcache_q    <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            kcache_q    <= kcache_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign pt_out    = out_valid ? st_q : '0;
    assign key_valid = key_valid_q;

endmodule
